hazard_ctrl: RTL

Issue controller for the Decode stage. Tracks pending register-file writes in a 32-entry scoreboard and gates each decoded instruction into Execute: stall on RAW/WAW hazards, squash on Execute redirects, drain on request. Sits beside Decode and drives its `exec_flush_i`; its own ready output replaces Decode's pass-through `ftch_ready_o` toward Fetch.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_ctrl_if.sv | 44 ++++
 rtl/hazard_ctrl_reg_scoreboard.sv | 60 ++++++
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the Decode-stage issue controller.
package hazard_pkg;

   localparam int NUM_ARCH_REGS = 32;

   typedef logic [4:0] reg_addr_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      DRAIN = 2'd2
   } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode / Execute / write-back signal bundle seen by the issue controller.
interface hazard_ctrl_if #(
   parameter int STALL_CNT_W = 32
);
   import hazard_pkg::*;

   logic                   dec_valid_i;
   reg_addr_t              dec_rs1_addr_i;
   reg_addr_t              dec_rs2_addr_i;
   logic                   dec_rs1_used_i;
   logic                   dec_rs2_used_i;
   reg_addr_t              dec_rd_addr_i;
   logic                   dec_rd_wr_i;
   logic                   exec_ready_i;
   logic                   exec_redirect_i;
   reg_addr_t              wb_rd_addr_i;
   logic                   wb_rd_en_i;
   logic                   drain_i;
   logic                   dec_issue_o;
   logic                   exec_flush_o;
   logic                   ftch_ready_o;
   logic                   busy_o;
   logic                   drain_done_o;
   logic [STALL_CNT_W-1:0] stall_cnt_o;

   // Pipeline side: drives decode/execute/write-back status, observes the gating.
   modport master (
      output dec_valid_i, dec_rs1_addr_i, dec_rs2_addr_i, dec_rs1_used_i,
             dec_rs2_used_i, dec_rd_addr_i, dec_rd_wr_i, exec_ready_i,
             exec_redirect_i, wb_rd_addr_i, wb_rd_en_i, drain_i,
      input  dec_issue_o, exec_flush_o, ftch_ready_o, busy_o, drain_done_o,
             stall_cnt_o
   );

   // Controller side.
   modport slave (
      input  dec_valid_i, dec_rs1_addr_i, dec_rs2_addr_i, dec_rs1_used_i,
             dec_rs2_used_i, dec_rd_addr_i, dec_rd_wr_i, exec_ready_i,
             exec_redirect_i, wb_rd_addr_i, wb_rd_en_i, drain_i,
      output dec_issue_o, exec_flush_o, ftch_ready_o, busy_o, drain_done_o,
             stall_cnt_o
   );

endinterface

// File: rtl/hazard_ctrl_reg_scoreboard.sv
// One pending-write bit per architectural register plus an inflight count.
// Lookups use the registered bits only; a same-cycle clear is not bypassed.
module reg_scoreboard
   import hazard_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      set_en,
   input  reg_addr_t set_addr,
   input  logic      clr_en,
   input  reg_addr_t clr_addr,
   input  reg_addr_t rs1_addr,
   input  reg_addr_t rs2_addr,
   input  reg_addr_t rd_addr,
   output logic      rs1_hit,
   output logic      rs2_hit,
   output logic      rd_hit,
   output logic [5:0] count
);

   logic [NUM_ARCH_REGS-1:0] sb;
   logic [NUM_ARCH_REGS-1:0] sb_next;
   logic [5:0]               count_next;
   logic                     set_eff;
   logic                     clr_eff;

   // x0 is never tracked.
   assign set_eff = set_en && (set_addr != '0);
   assign clr_eff = clr_en && (clr_addr != '0);

   assign rs1_hit = sb[rs1_addr];
   assign rs2_hit = sb[rs2_addr];
   assign rd_hit  = sb[rd_addr];

   // Next scoreboard bits and inflight count.
   always_comb begin
      sb_next    = sb;
      count_next = count;
      if (clr_eff) sb_next[clr_addr] = 1'b0;
      if (set_eff) sb_next[set_addr] = 1'b1;
      sb_next[0] = 1'b0;
      unique case ({set_eff, clr_eff})
         2'b10:   count_next = count + 6'd1;
         2'b01:   count_next = count - 6'd1;
         default: count_next = count;
      endcase
   end

   // Scoreboard and count registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb    <= '0;
         count <= '0;
      end else begin
         sb    <= sb_next;
         count <= count_next;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage issue controller: stalls on RAW/WAW, squashes after redirects,
// and drains pending writes on request.
//
// state | meaning
// ------+----------------------------------------------------------
// RUN   | normal issue; hazards stall Decode and bubble Execute
// FLUSH | squashing wrong-path instructions after a redirect
// DRAIN | no issue, Fetch held, waiting for all pending writes
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int STALL_CNT_W  = 32
)(
   input  logic         clk_i,
   input  logic         rst_i,
   hazard_ctrl_if.slave bus
);

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   hazard_state_t          state;
   hazard_state_t          state_next;
   logic [2:0]             flush_cnt;
   logic [2:0]             flush_cnt_next;
   logic                   drain_done;
   logic                   drain_done_next;
   logic [STALL_CNT_W-1:0] stall_cnt;
   logic [5:0]             count;
   logic                   rs1_hit;
   logic                   rs2_hit;
   logic                   rd_hit;
   logic                   hazard;
   logic                   in_run;
   logic                   in_flush;
   logic                   in_drain;
   logic                   redirect;
   logic                   offer;
   logic                   issue;
   logic                   stall_event;

   reg_scoreboard u_sb (
      .clk      (clk_i),
      .rst      (rst_i),
      .set_en   (issue && bus.dec_rd_wr_i),
      .set_addr (bus.dec_rd_addr_i),
      .clr_en   (bus.wb_rd_en_i),
      .clr_addr (bus.wb_rd_addr_i),
      .rs1_addr (bus.dec_rs1_addr_i),
      .rs2_addr (bus.dec_rs2_addr_i),
      .rd_addr  (bus.dec_rd_addr_i),
      .rs1_hit  (rs1_hit),
      .rs2_hit  (rs2_hit),
      .rd_hit   (rd_hit),
      .count    (count)
   );

   assign in_run   = (state == RUN);
   assign in_flush = (state == FLUSH);
   assign in_drain = (state == DRAIN);
   assign redirect = bus.exec_redirect_i;
   assign offer    = bus.dec_valid_i && bus.exec_ready_i;

   assign hazard = (bus.dec_rs1_used_i && rs1_hit) ||
                   (bus.dec_rs2_used_i && rs2_hit) ||
                   (bus.dec_rd_wr_i    && rd_hit);

   assign issue       = !rst_i && in_run && !redirect && offer && !hazard;
   assign stall_event = in_run && offer && hazard && !redirect;

   // The hazard bubble keeps a stalled instruction from being duplicated into Execute.
   assign bus.dec_issue_o  = issue;
   assign bus.exec_flush_o = rst_i || redirect || in_flush || in_drain ||
                             (in_run && offer && hazard);
   assign bus.ftch_ready_o = !rst_i && bus.exec_ready_i && !in_drain &&
                             !(in_run && !redirect && bus.dec_valid_i && hazard);
   assign bus.busy_o       = (count != '0);
   assign bus.drain_done_o = drain_done;
   assign bus.stall_cnt_o  = stall_cnt;

   // Next-state: redirect wins, then the flush timer, then drain entry/exit.
   always_comb begin
      state_next      = state;
      flush_cnt_next  = flush_cnt;
      drain_done_next = 1'b0;
      if (redirect) begin
         if (FLUSH_CYCLES > 1) begin
            state_next     = FLUSH;
            flush_cnt_next = FLUSH_LOAD;
         end else begin
            state_next = RUN;
         end
      end else begin
         unique case (state)
            RUN: begin
               if (bus.drain_i) state_next = DRAIN;
            end
            FLUSH: begin
               flush_cnt_next = flush_cnt - 3'd1;
               if (flush_cnt == 3'd1) state_next = RUN;
            end
            DRAIN: begin
               if (count == '0) begin
                  state_next      = RUN;
                  drain_done_next = 1'b1;
               end
            end
            default: state_next = RUN;
         endcase
      end
   end

   // State, flush timer and registered done pulse.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= RUN;
         flush_cnt  <= '0;
         drain_done <= 1'b0;
      end else begin
         state      <= state_next;
         flush_cnt  <= flush_cnt_next;
         drain_done <= drain_done_next;
      end
   end

   // Saturating hazard-stall counter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt <= '0;
      end else if (stall_event && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
